// File: rtl/jogo_pkg.sv
// jogo_pkg: shared definitions for the sequence-memory game core.
//   estado_t  - 4-bit FSM state codes, also exported on db_estado
//   largura   - address/counter width from a count (never below 1 bit)
//   eh_onehot - true when exactly one bit of a move vector is set
package jogo_pkg;

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      MOSTRA         = 4'd2,
      ESPERA         = 4'd3,
      COMPARA        = 4'd4,
      PROXIMA        = 4'd5,
      ESPERA_NOVA    = 4'd6,
      ESCREVE        = 4'd7,
      PROXIMA_RODADA = 4'd8,
      GANHOU         = 4'd9,
      PERDEU         = 4'd10
   } estado_t;

   function automatic int largura(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Move vectors are zero-extended to 32 bits, so N_BOTOES must stay <= 32.
   function automatic logic eh_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/detector_jogada.sv
// detector_jogada: turns debounced button levels into one-cycle move events.
//   i_clock, i_reset - clock, synchronous active-high reset
//   i_botoes         - button levels
//   o_jogada         - registered pulse, one cycle after |i_botoes rises
//   o_valor          - button vector sampled in the rising-edge cycle
// Releases and extra buttons pressed while another is held produce no event.
module detector_jogada #(
   parameter int N = 4
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic [N-1:0] i_botoes,
   output logic         o_jogada,
   output logic [N-1:0] o_valor
);

   logic         r_prev;
   logic         r_jogada;
   logic [N-1:0] r_valor;
   logic         w_algum;
   logic         w_borda;

   assign w_algum = |i_botoes;
   assign w_borda = w_algum & ~r_prev;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_prev   <= 1'b0;
         r_jogada <= 1'b0;
         r_valor  <= '0;
      end else begin
         r_prev   <= w_algum;
         r_jogada <= w_borda;
         if (w_borda) r_valor <= i_botoes;
      end
   end

   assign o_jogada = r_jogada;
   assign o_valor  = r_valor;

endmodule

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: parametrised sequence-memory game controller.
//   clock, reset     - clock, synchronous active-high reset
//   iniciar          - start/restart level (INICIAL, GANHOU, PERDEU)
//   modo_timeout     - 1 enables the between-moves timeout, latched at start
//   botoes           - debounced button levels
//   leds             - RAM[0] while showing, button echo while waiting
//   pronto/ganhou/perdeu - game-over flags, held until restart
//   db_rodada/db_endereco/db_estado/db_timeout - debug visibility
module jogo_sequencia_param
   import jogo_pkg::*;
#(
   parameter int N_BOTOES       = 4,
   parameter int PROFUNDIDADE   = 16,
   parameter int TEMPO_LED      = 2000,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int JOGADA_INICIAL = 1
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                iniciar,
   input  logic                                modo_timeout,
   input  logic [N_BOTOES-1:0]                 botoes,
   output logic [N_BOTOES-1:0]                 leds,
   output logic                                pronto,
   output logic                                ganhou,
   output logic                                perdeu,
   output logic [largura(PROFUNDIDADE)-1:0]    db_rodada,
   output logic [largura(PROFUNDIDADE)-1:0]    db_endereco,
   output logic [3:0]                          db_estado,
   output logic                                db_timeout
);

   localparam int WE   = largura(PROFUNDIDADE);
   localparam int MAXC = (TEMPO_LED > TIMEOUT_CICLOS) ? TEMPO_LED : TIMEOUT_CICLOS;
   localparam int WC   = largura(MAXC);

   estado_t             r_estado;
   logic [WE-1:0]       r_rodada;
   logic [WE-1:0]       r_endereco;
   logic [WC-1:0]       r_cnt;      // MOSTRA duration and wait timeout share it
   logic                r_modo;
   logic                r_pronto;
   logic                r_ganhou;
   logic                r_perdeu;
   logic                r_timeout;
   logic [N_BOTOES-1:0] r_ram [PROFUNDIDADE];

   logic                w_jogada;
   logic [N_BOTOES-1:0] w_valor;
   logic                w_onehot;
   logic                w_igual;
   logic                w_we;
   logic [WE-1:0]       w_waddr;
   logic [N_BOTOES-1:0] w_wdata;
   logic [N_BOTOES-1:0] w_leds;

   detector_jogada #(.N(N_BOTOES)) u_det (
      .i_clock  (clock),
      .i_reset  (reset),
      .i_botoes (botoes),
      .o_jogada (w_jogada),
      .o_valor  (w_valor)
   );

   assign w_onehot = eh_onehot(32'(w_valor));
   // Stored moves are one-hot, but guard anyway so a multi-hot press can never match.
   assign w_igual  = (w_valor == r_ram[r_endereco]) && w_onehot;

   // RAM: seeded at PREPARA, extended at ESCREVE; contents survive reset.
   assign w_we    = !reset && (r_estado == PREPARA || r_estado == ESCREVE);
   assign w_waddr = (r_estado == PREPARA) ? '0 : r_rodada + WE'(1);
   assign w_wdata = (r_estado == PREPARA) ? N_BOTOES'(JOGADA_INICIAL) : w_valor;

   always_ff @(posedge clock) begin
      if (w_we) r_ram[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= INICIAL;
         r_rodada   <= '0;
         r_endereco <= '0;
         r_cnt      <= '0;
         r_modo     <= 1'b0;
         r_pronto   <= 1'b0;
         r_ganhou   <= 1'b0;
         r_perdeu   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_estado)
            INICIAL: if (iniciar) r_estado <= PREPARA;
            PREPARA: begin
               r_rodada   <= '0;
               r_endereco <= '0;
               r_cnt      <= '0;
               r_modo     <= modo_timeout;
               r_estado   <= MOSTRA;
            end
            MOSTRA: begin
               if (r_cnt == WC'(TEMPO_LED - 1)) begin
                  r_cnt    <= '0;
                  r_estado <= ESPERA;
               end else begin
                  r_cnt <= r_cnt + WC'(1);
               end
            end
            ESPERA, ESPERA_NOVA: begin
               // A press in the terminal-count cycle takes priority over the timeout.
               if (w_jogada) begin
                  r_cnt <= '0;
                  if (r_estado == ESPERA) r_estado <= COMPARA;
                  else if (w_onehot)      r_estado <= ESCREVE;
               end else if (r_modo) begin
                  if (r_cnt == WC'(TIMEOUT_CICLOS - 1)) begin
                     r_timeout <= 1'b1;
                     r_pronto  <= 1'b1;
                     r_perdeu  <= 1'b1;
                     r_estado  <= PERDEU;
                  end else begin
                     r_cnt <= r_cnt + WC'(1);
                  end
               end
            end
            COMPARA: begin
               r_cnt <= '0;
               if (!w_igual) begin
                  r_pronto <= 1'b1;
                  r_perdeu <= 1'b1;
                  r_estado <= PERDEU;
               end else if (r_endereco != r_rodada) begin
                  r_estado <= PROXIMA;
               end else if (r_rodada == WE'(PROFUNDIDADE - 1)) begin
                  r_pronto <= 1'b1;
                  r_ganhou <= 1'b1;
                  r_estado <= GANHOU;
               end else begin
                  r_estado <= ESPERA_NOVA;
               end
            end
            PROXIMA: begin
               r_endereco <= r_endereco + WE'(1);
               r_cnt      <= '0;
               r_estado   <= ESPERA;
            end
            ESCREVE: r_estado <= PROXIMA_RODADA;
            PROXIMA_RODADA: begin
               r_rodada   <= r_rodada + WE'(1);
               r_endereco <= '0;
               r_cnt      <= '0;
               r_estado   <= ESPERA;
            end
            GANHOU, PERDEU: begin
               if (iniciar) begin
                  r_pronto <= 1'b0;
                  r_ganhou <= 1'b0;
                  r_perdeu <= 1'b0;
                  r_estado <= PREPARA;
               end
            end
            default: r_estado <= INICIAL;
         endcase
      end
   end

   always_comb begin
      w_leds = '0;
      case (r_estado)
         MOSTRA:              w_leds = r_ram[0];
         ESPERA, ESPERA_NOVA: w_leds = botoes;
         default:             w_leds = '0;
      endcase
   end

   assign leds        = w_leds;
   assign pronto      = r_pronto;
   assign ganhou      = r_ganhou;
   assign perdeu      = r_perdeu;
   assign db_rodada   = r_rodada;
   assign db_endereco = r_endereco;
   assign db_estado   = r_estado;
   assign db_timeout  = r_timeout;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
module tb_jogo_sequencia_param;

   localparam logic [3:0] S_INI  = 4'd0;
   localparam logic [3:0] S_PREP = 4'd1;
   localparam logic [3:0] S_ESP  = 4'd3;
   localparam logic [3:0] S_NOVA = 4'd6;
   localparam logic [3:0] S_GAN  = 4'd9;
   localparam logic [3:0] S_PER  = 4'd10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       modo_timeout = 1'b0;
   logic [3:0] botoes = 4'b0000;
   logic [3:0] leds;
   logic       pronto, ganhou, perdeu, db_timeout;
   logic [3:0] db_rodada, db_endereco, db_estado;

   int n_chk = 0;
   int n_err = 0;

   jogo_sequencia_param dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .modo_timeout (modo_timeout),
      .botoes       (botoes),
      .leds         (leds),
      .pronto       (pronto),
      .ganhou       (ganhou),
      .perdeu       (perdeu),
      .db_rodada    (db_rodada),
      .db_endereco  (db_endereco),
      .db_estado    (db_estado),
      .db_timeout   (db_timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] b;
      logic [3:0] est;
      logic [3:0] rod;
   } vec_t;

   vec_t       tab [23];
   logic [3:0] seq_a [16];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press(input logic [3:0] v);
      botoes = v;
      tick(3);
      botoes = 4'b0000;
      tick(3);
   endtask

   // Deciding press: flag must still be low one cycle after the edge cycle, high two after.
   task automatic press_lat(input logic [3:0] v, input bit win, input string nm);
      botoes = v;
      tick(2);
      chk({nm, " flag early"}, win ? int'(ganhou) : int'(perdeu), 0);
      tick(1);
      chk({nm, " flag on time"}, win ? int'(ganhou) : int'(perdeu), 1);
      botoes = 4'b0000;
      tick(3);
   endtask

   task automatic wait_estado(input logic [3:0] e, input int bound, input string nm);
      int n = 0;
      while (db_estado != e && n < bound) begin
         tick(1);
         n++;
      end
      chk(nm, int'(db_estado), int'(e));
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, int'({leds, pronto, ganhou, perdeu, db_rodada, db_endereco, db_estado, db_timeout}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int on;
      int pulses;
      int n;

      // game B vectors: press, expected state and round once the press has settled
      tab[0]  = '{4'b0001, S_NOVA, 4'd0};
      tab[1]  = '{4'b0100, S_ESP,  4'd1};
      tab[2]  = '{4'b0001, S_ESP,  4'd1};
      tab[3]  = '{4'b0100, S_NOVA, 4'd1};
      tab[4]  = '{4'b0110, S_NOVA, 4'd1};  // multi-hot insert rejected
      tab[5]  = '{4'b0010, S_ESP,  4'd2};
      tab[6]  = '{4'b0001, S_ESP,  4'd2};
      tab[7]  = '{4'b0100, S_ESP,  4'd2};
      tab[8]  = '{4'b0010, S_NOVA, 4'd2};  // the 0010 insert is what is now expected
      tab[9]  = '{4'b1000, S_ESP,  4'd3};
      tab[10] = '{4'b0001, S_ESP,  4'd3};
      tab[11] = '{4'b0100, S_ESP,  4'd3};
      tab[12] = '{4'b0010, S_ESP,  4'd3};
      tab[13] = '{4'b1000, S_NOVA, 4'd3};
      tab[14] = '{4'b0001, S_ESP,  4'd4};
      tab[15] = '{4'b0001, S_ESP,  4'd4};
      tab[16] = '{4'b0100, S_ESP,  4'd4};
      tab[17] = '{4'b0010, S_ESP,  4'd4};
      tab[18] = '{4'b1000, S_ESP,  4'd4};
      tab[19] = '{4'b0001, S_NOVA, 4'd4};
      tab[20] = '{4'b0010, S_ESP,  4'd5};
      tab[21] = '{4'b0001, S_ESP,  4'd5};
      tab[22] = '{4'b0100, S_ESP,  4'd5};

      seq_a[0] = 4'b0001;
      for (int k = 1; k < 16; k++) seq_a[k] = 4'b0001 << ((k + 1) % 4);

      // reset state
      tick(3);
      chk_zero("reset outputs");
      reset = 1'b0;
      tick(1);
      chk("idle state", int'(db_estado), int'(S_INI));

      // game A: show phase length, then a full win with timeout enabled
      modo_timeout = 1'b1;
      iniciar = 1'b1;
      on = 0;
      for (int c = 0; c < 2100; c++) begin
         tick(1);
         if (c == 10) iniciar = 1'b0;
         if (leds == 4'b0001) on++;
         if (on > 0 && leds != 4'b0001) break;
      end
      chk("show cycles", on, 2000);
      chk("after show state", int'(db_estado), int'(S_ESP));
      chk("after show pronto", int'(pronto), 0);

      for (int r = 0; r < 16; r++) begin
         chk($sformatf("win round %0d", r), int'(db_rodada), r);
         for (int i = 0; i <= r; i++) begin
            if (r == 15 && i == 15) press_lat(seq_a[i], 1'b1, "win");
            else press(seq_a[i]);
         end
         if (r < 15) press(seq_a[r + 1]);
      end
      chk("win ganhou", int'(ganhou), 1);
      chk("win pronto", int'(pronto), 1);
      chk("win perdeu", int'(perdeu), 0);
      chk("win rodada", int'(db_rodada), 15);
      chk("win state", int'(db_estado), int'(S_GAN));

      // game B: restart from GANHOU, timeout disabled, vector table
      modo_timeout = 1'b0;
      iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
      chk("restart state", int'(db_estado), int'(S_PREP));
      chk("restart ganhou clear", int'(ganhou), 0);
      wait_estado(S_ESP, 2100, "B reach wait");
      for (int i = 0; i < 23; i++) begin
         press(tab[i].b);
         chk($sformatf("vec %0d state", i), int'(db_estado), int'(tab[i].est));
         chk($sformatf("vec %0d round", i), int'(db_rodada), int'(tab[i].rod));
      end
      chk("B move index", int'(db_endereco), 2);

      pulses = 0;
      for (int c = 0; c < 5100; c++) begin
         tick(1);
         if (db_timeout) pulses++;
      end
      chk("no-timeout pulses", pulses, 0);
      chk("no-timeout state", int'(db_estado), int'(S_ESP));

      // reset mid-round 5
      reset = 1'b1;
      tick(1);
      chk_zero("mid reset outputs");
      reset = 1'b0;

      // game C: restart, then wrong move in round 2
      modo_timeout = 1'b1;
      iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
      wait_estado(S_ESP, 2100, "C reach wait");
      press(4'b0001);
      chk("C round0 ok", int'(db_estado), int'(S_NOVA));
      press(4'b0100);
      chk("C round1", int'(db_rodada), 1);
      press(4'b0001);
      press(4'b0100);
      press(4'b1000);
      chk("C round2", int'(db_rodada), 2);
      press(4'b0001);
      press_lat(4'b1000, 1'b0, "wrong");
      chk("wrong ganhou", int'(ganhou), 0);
      chk("wrong pronto", int'(pronto), 1);
      chk("wrong state", int'(db_estado), int'(S_PER));

      // game D: idle in ESPERA with timeout enabled
      iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
      chk("D perdeu clear", int'(perdeu), 0);
      wait_estado(S_ESP, 2100, "D reach wait");
      n = 0;
      while (db_estado == S_ESP && n < 6000) begin
         tick(1);
         n++;
      end
      chk("timeout cycles", n, 5000);
      chk("timeout pulse", int'(db_timeout), 1);
      chk("timeout perdeu", int'(perdeu), 1);
      tick(1);
      chk("timeout pulse end", int'(db_timeout), 0);
      chk("timeout held", int'(perdeu), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
- Parametrised sequence-memory game controller; next generation of the exp7 game core.
- Generalised in button count, sequence depth, show time and timeout length.
- New behaviour: run-time timeout enable and rejection of non-one-hot inserted moves.
- Each round the player repeats the stored sequence, then inserts one new move, which is written to internal RAM. Sits between the debounced button inputs and the LED/display layer.

Parameters:
N_BOTOES, 4, number of buttons/LEDs (≥2).
PROFUNDIDADE, 16, max sequence length = number of rounds.
TEMPO_LED, 2000, cycles the first move is shown at game start.
TIMEOUT_CICLOS, 5000, cycles allowed between moves before loss.
JOGADA_INICIAL, 1, one-hot move preloaded at RAM address 0 on start.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start/restart game (level, sampled in idle/final states)
modo_timeout  in  1  1 = timeout enabled, 0 = disabled; sampled at start
botoes  in  N_BOTOES  button levels
leds  out  N_BOTOES  LED drive
pronto  out  1  game over (win or loss)
ganhou  out  1  win flag
perdeu  out  1  loss flag
db_rodada  out  clog2(PROFUNDIDADE)  current round index
db_endereco  out  clog2(PROFUNDIDADE)  current move index
db_estado  out  4  FSM state code
db_timeout  out  1  timeout event pulse

Behaviour:
- Reset (sync, high): state INICIAL; all outputs 0; counters 0; mode register 0. Reset overrides every state, including mid-game.
- Move detection: jogada = rising edge of |botoes (registered). The value captured is botoes in the edge cycle. Player releases are ignored.
- FSM:
  - INICIAL: wait for iniciar=1.
  - PREPARA: one cycle. Clear rodada and endereco; write JOGADA_INICIAL to addr 0; latch modo_timeout.
  - MOSTRA: leds=RAM[0] for TEMPO_LED cycles, then go to ESPERA.
  - ESPERA: wait for jogada. If timeout is enabled and the counter reaches TIMEOUT_CICLOS-1, pulse db_timeout for 1 cycle and go to PERDEU.
  - COMPARA: 1 cycle. Equal means captured value == RAM[endereco], exact vector match. Multi-hot never matches.
    - Not equal → PERDEU.
    - Equal and endereco≠rodada → PROXIMA: endereco+1, then ESPERA.
    - Equal and endereco==rodada: if rodada==PROFUNDIDADE-1 → GANHOU; else → ESPERA_NOVA.
  - ESPERA_NOVA: wait for jogada (timeout applies). Captured value not one-hot → ignored, stay in state, timeout counter cleared. One-hot → ESCREVE.
  - ESCREVE: write captured value to RAM[rodada+1], then go to PROXIMA_RODADA.
  - PROXIMA_RODADA: rodada+1, endereco=0, then ESPERA.
  - GANHOU / PERDEU: pronto=1 and the matching flag=1, held. iniciar=1 → PREPARA; flags clear on leaving.
- Timeout counter clears on entry to ESPERA/ESPERA_NOVA and on every jogada. It counts only while waiting and enabled.
- leds: RAM[0] in MOSTRA; botoes echoed in ESPERA/ESPERA_NOVA; 0 elsewhere.
- RAM: PROFUNDIDADE×N_BOTOES; synchronous write, asynchronous read. Contents are not reset (only addr 0 is written at PREPARA).
- A jogada arriving in any other state is dropped.
- Simultaneous jogada and timeout terminal count: the jogada wins.
- Latency: the game-over flag rises 2 cycles after the edge cycle of the deciding press.

Decomposition:
- Shared package jogo_pkg holds:
  - state-code constants (4-bit);
  - clog2-based width localparam helper;
  - one-hot check function.
- Natural sub-module: detector_jogada, a registered OR-edge detector that also captures the button vector.
- RAM and counters stay inline.

Test Plan:
- Reset then iniciar=1 for 10 cycles: leds=0001 for exactly 2000 cycles; db_estado=ESPERA afterwards; pronto=0.
- Full win, PROFUNDIDADE=16, modo_timeout=1: replay the correct sequence each round and insert 0100,1000,0001… on rounds 0–14. Required: ganhou=1, pronto=1, db_rodada=15, perdeu=0.
- Wrong move: round 2, second move pressed as 1000 against stored 0100 → perdeu=1 two cycles after the edge; ganhou=0.
- Timeout: modo_timeout=1, no press for 5000 cycles in ESPERA → db_timeout pulses once, perdeu=1. Same stimulus with modo_timeout=0 → stays in ESPERA.
- Insertion of 0110 in ESPERA_NOVA → no write, state unchanged. Then 0010 → RAM[rodada+1]=0010 and the next round expects 0010.
- Reset asserted mid-round 5 → next cycle all outputs 0, state INICIAL. Restart via iniciar plays round 0 correctly.
